// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush controller for the 5-stage MIPS pipeline.
// Each cycle it selects one control rule: reset fill, memory freeze, branch flush,
// load-use/HI-LO stall, fetch wait or free run. It also tracks how long HI/LO is
// occupied by an in-flight multiply/divide.
// Optional build macro: HAZARD_STATS_EN adds saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        i_Clk,
  input  logic        Reset,
  input  logic [4:0]  i_ID_Rs,
  input  logic [4:0]  i_ID_Rt,
  input  logic        i_ID_UseRs,
  input  logic        i_ID_UseRt,
  input  logic        i_ID_MdRead,
  input  logic        i_ID_MdOp,
  input  logic [4:0]  i_EX_Rd,
  input  logic        i_EX_MemRead,
  input  logic        i_EX_MdStart,
  input  logic        i_EX_MdIsDiv,
  input  logic        i_EX_BranchTaken,
  input  logic        i_IMem_Ready,
  input  logic        i_DMem_Ready,
  output logic        o_PC_WE_n,
  output logic        o_F_WE_n,
  output logic        o_F_CLR,
  output logic        o_D_CLR,
  output logic        o_E_WE_n,
  output logic        o_MD_Busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] o_StallCnt,
  output logic [31:0] o_FlushCnt
`endif
);

  typedef enum logic [2:0] {
    RULE_RESET,
    RULE_FREEZE,
    RULE_FLUSH,
    RULE_HAZARD,
    RULE_IWAIT,
    RULE_RUN
  } rule_e;

  // Counter reload values: the start cycle itself is the first busy cycle in EX,
  // so the counter covers the remaining CYCLES-1.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] md_cnt_q;
  logic [CNT_W-1:0] md_cnt_d;
  logic             md_pending;
  logic             rs_match;
  logic             rt_match;
  logic             lu_haz;
  logic             md_haz;
  logic             md_accept;
  rule_e            rule;

  // Hazard detection of the ID instruction against EX and the HI/LO counter
  always_comb begin
    md_pending = (md_cnt_q != '0);
    rs_match   = i_ID_UseRs & (i_ID_Rs == i_EX_Rd);
    rt_match   = i_ID_UseRt & (i_ID_Rt == i_EX_Rd);
    lu_haz     = i_EX_MemRead & (i_EX_Rd != 5'd0) & (rs_match | rt_match);
    md_haz     = (i_ID_MdRead | i_ID_MdOp) & (md_pending | i_EX_MdStart);
    // A start frozen in EX by a data-memory wait is taken only once, when it moves on
    md_accept  = i_EX_MdStart & i_DMem_Ready;
  end

  // Priority select: exactly one rule governs the pipeline each cycle
  always_comb begin
    if (Reset) begin
      rule = RULE_RESET;
    end else if (!i_DMem_Ready) begin
      rule = RULE_FREEZE;
    end else if (i_EX_BranchTaken) begin
      rule = RULE_FLUSH;
    end else if (lu_haz | md_haz) begin
      rule = RULE_HAZARD;
    end else if (!i_IMem_Ready) begin
      rule = RULE_IWAIT;
    end else begin
      rule = RULE_RUN;
    end
  end

  // Decode stage controls from the selected rule
  always_comb begin
    o_PC_WE_n = 1'b0;
    o_F_WE_n  = 1'b0;
    o_F_CLR   = 1'b0;
    o_D_CLR   = 1'b0;
    o_E_WE_n  = 1'b0;
    case (rule)
      RULE_RESET: begin
        o_F_CLR = 1'b1;
        o_D_CLR = 1'b1;
      end
      RULE_FREEZE: begin
        o_PC_WE_n = 1'b1;
        o_F_WE_n  = 1'b1;
        o_E_WE_n  = 1'b1;
      end
      RULE_FLUSH: begin
        o_F_CLR = 1'b1;
        o_D_CLR = 1'b1;
      end
      RULE_HAZARD: begin
        o_PC_WE_n = 1'b1;
        o_F_WE_n  = 1'b1;
        o_D_CLR   = 1'b1;
      end
      RULE_IWAIT: begin
        o_PC_WE_n = 1'b1;
        o_F_CLR   = 1'b1;
      end
      default: begin
        o_PC_WE_n = 1'b0;
      end
    endcase
    o_MD_Busy = md_pending;
  end

  // MD busy counter next state: reload on an accepted start, else count down
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_accept) begin
      md_cnt_d = i_EX_MdIsDiv ? DIV_LOAD : MUL_LOAD;
    end else if (md_pending) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  // MD busy counter register
  always_ff @(posedge i_Clk) begin
    if (Reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;
  logic        is_stall;
  logic        is_flush;

  // Saturating event counters for stall and flush cycles
  always_comb begin
    is_stall    = (rule == RULE_FREEZE) | (rule == RULE_HAZARD) | (rule == RULE_IWAIT);
    is_flush    = (rule == RULE_FLUSH);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (is_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (is_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge i_Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Statistics outputs
  always_comb begin
    o_StallCnt = stall_cnt_q;
    o_FlushCnt = flush_cnt_q;
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a cycle-numbered reference model.
module tb_pipeline_hazard_ctrl;

  localparam int MULC = 4;
  localparam int DIVC = 32;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_urs, id_urt, id_mdr, id_mdo;
  logic       ex_mr, ex_ms, ex_dv, ex_br, imem_rdy, dmem_rdy;
  logic       pc_we_n, f_we_n, f_clr, d_clr, e_we_n, md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipeline_hazard_ctrl #(
    .MUL_CYCLES(MULC),
    .DIV_CYCLES(DIVC),
    .CNT_W(6)
  ) dut (
    .i_Clk(clk),
    .Reset(rst),
    .i_ID_Rs(id_rs),
    .i_ID_Rt(id_rt),
    .i_ID_UseRs(id_urs),
    .i_ID_UseRt(id_urt),
    .i_ID_MdRead(id_mdr),
    .i_ID_MdOp(id_mdo),
    .i_EX_Rd(ex_rd),
    .i_EX_MemRead(ex_mr),
    .i_EX_MdStart(ex_ms),
    .i_EX_MdIsDiv(ex_dv),
    .i_EX_BranchTaken(ex_br),
    .i_IMem_Ready(imem_rdy),
    .i_DMem_Ready(dmem_rdy),
    .o_PC_WE_n(pc_we_n),
    .o_F_WE_n(f_we_n),
    .o_F_CLR(f_clr),
    .o_D_CLR(d_clr),
    .o_E_WE_n(e_we_n),
    .o_MD_Busy(md_busy)
`ifdef HAZARD_STATS_EN
    ,
    .o_StallCnt(stall_cnt),
    .o_FlushCnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs, urt, mdr, mdo;
    logic [4:0] rd;
    logic       mr, ms, dv, br, im, dm;
  } in_t;

  typedef struct {
    in_t        in;
    logic [5:0] exp;  // {pc_we_n, f_we_n, f_clr, d_clr, e_we_n, md_busy}
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model state: absolute cycle number, and the first cycle at which
  // HI/LO is no longer pending.
  int cyc       = 0;
  int md_until  = 0;
  int m_stalls  = 0;
  int m_flushes = 0;

  function automatic in_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic mdr, input logic mdo,
                             input logic [4:0] rd, input logic mr, input logic ms, input logic dv,
                             input logic br, input logic im, input logic dm);
    in_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mdr = mdr; v.mdo = mdo;
    v.rd = rd; v.mr = mr; v.ms = ms; v.dv = dv; v.br = br; v.im = im; v.dm = dm;
    return v;
  endfunction

  // kind: 0 reset, 1 stall-type, 2 flush, 3 run
  function automatic logic [5:0] model_out(input in_t v, output int kind);
    bit busy, lu, md;
    busy = (cyc < md_until);
    lu   = v.mr && (v.rd != 0) && ((v.urs && v.rs == v.rd) || (v.urt && v.rt == v.rd));
    md   = (v.mdr || v.mdo) && (busy || v.ms);
    if (v.rst)            begin kind = 0; return {5'b00110, busy}; end
    else if (!v.dm)       begin kind = 1; return {5'b11001, busy}; end
    else if (v.br)        begin kind = 2; return {5'b00110, busy}; end
    else if (lu || md)    begin kind = 1; return {5'b11010, busy}; end
    else if (!v.im)       begin kind = 1; return {5'b10100, busy}; end
    else                  begin kind = 3; return {5'b00000, busy}; end
  endfunction

  task automatic model_step(input in_t v, input int kind);
    if (v.rst) begin
      md_until  = 0;
      m_stalls  = 0;
      m_flushes = 0;
    end else begin
      if (v.ms && v.dm) md_until = cyc + (v.dv ? DIVC : MULC);
      if (kind == 1) m_stalls++;
      if (kind == 2) m_flushes++;
    end
    cyc++;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic drive(input in_t v);
    rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_urs = v.urs; id_urt = v.urt;
    id_mdr = v.mdr; id_mdo = v.mdo; ex_rd = v.rd; ex_mr = v.mr; ex_ms = v.ms;
    ex_dv = v.dv; ex_br = v.br; imem_rdy = v.im; dmem_rdy = v.dm;
  endtask

  // One clock cycle: apply inputs, compare at the falling edge, advance model
  task automatic run_cycle(input in_t v, input bit chk, output logic [5:0] got);
    logic [5:0] exp;
    int kind;
    drive(v);
    @(negedge clk);
    got = {pc_we_n, f_we_n, f_clr, d_clr, e_we_n, md_busy};
    exp = model_out(v, kind);
    if (chk) begin
      check("model_ctrl", {26'd0, got}, {26'd0, exp});
`ifdef HAZARD_STATS_EN
      check("model_stallcnt", stall_cnt, m_stalls);
      check("model_flushcnt", flush_cnt, m_flushes);
`endif
    end
    model_step(v, kind);
    @(posedge clk);
    #1;
  endtask

  vec_t       tbl[14];
  in_t        idle, rnd;
  logic [5:0] got;
  int         busy_n, stall_n;

  initial begin
    idle = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 1);

    tbl[0]  = '{mk(0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd3, 0, 0, 0, 0, 1, 1), 6'b000000};
    tbl[1]  = '{mk(0, 5'd5, 5'd2, 1, 1, 0, 0, 5'd5, 1, 0, 0, 0, 1, 1), 6'b110100};
    tbl[2]  = '{mk(0, 5'd0, 5'd2, 1, 0, 0, 0, 5'd0, 1, 0, 0, 0, 1, 1), 6'b000000};
    tbl[3]  = '{mk(0, 5'd1, 5'd7, 0, 1, 0, 0, 5'd7, 1, 0, 0, 0, 1, 1), 6'b110100};
    tbl[4]  = '{mk(0, 5'd1, 5'd7, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0, 1, 1), 6'b000000};
    tbl[5]  = '{mk(0, 5'd6, 5'd1, 1, 1, 0, 0, 5'd7, 1, 0, 0, 0, 1, 1), 6'b000000};
    tbl[6]  = '{mk(0, 5'd5, 5'd2, 1, 0, 0, 0, 5'd5, 1, 0, 0, 1, 0, 1), 6'b001100};
    tbl[7]  = '{mk(0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd3, 0, 0, 0, 0, 0, 1), 6'b101000};
    tbl[8]  = '{mk(0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd3, 0, 0, 0, 0, 0, 1), 6'b101000};
    tbl[9]  = '{mk(0, 5'd5, 5'd2, 1, 0, 0, 0, 5'd5, 1, 0, 0, 0, 1, 0), 6'b110010};
    tbl[10] = '{mk(0, 5'd5, 5'd2, 1, 0, 0, 0, 5'd5, 1, 0, 0, 0, 0, 1), 6'b110100};
    tbl[11] = '{mk(0, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3, 0, 0, 0, 0, 1, 1), 6'b000000};
    tbl[12] = '{mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd3, 0, 0, 0, 1, 1, 0), 6'b110010};
    tbl[13] = '{mk(0, 5'd1, 5'd2, 0, 0, 0, 1, 5'd3, 0, 0, 0, 0, 1, 1), 6'b000000};

    drive(mk(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 1));
    @(posedge clk);
    #1;

    // Reset held two cycles; the first leaves the power-up counter undefined
    run_cycle(mk(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 1), 1'b0, got);
    run_cycle(mk(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 1), 1'b1, got);
    check("reset_ctrl", {26'd0, got}, {26'd0, 6'b001100});
    run_cycle(idle, 1'b1, got);
    check("post_reset_run", {26'd0, got}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_cycle(tbl[i].in, 1'b1, got);
      check($sformatf("vec%0d", i), {26'd0, got}, {26'd0, tbl[i].exp});
    end

    // Divide start with mfhi waiting in ID
    run_cycle(mk(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 1, 1, 0, 1, 1), 1'b1, got);
    check("div_start_stall", {26'd0, got}, {26'd0, 6'b110100});
    busy_n = 0;
    stall_n = 0;
    for (int k = 0; k < 40; k++) begin
      run_cycle(mk(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0, 0, 1, 1), 1'b1, got);
      if (got[0]) busy_n++;
      if (got[5]) stall_n++;
      else break;
    end
    check("div_busy_cycles", busy_n, DIVC - 1);
    check("div_stall_cycles", stall_n, DIVC - 1);
    check("div_release", {26'd0, got}, 32'd0);

    // Data-memory freeze with a taken branch and a multiply start held in EX
    for (int k = 0; k < 3; k++) begin
      run_cycle(mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 1, 1, 0), 1'b1, got);
      check($sformatf("freeze%0d", k), {26'd0, got}, {26'd0, 6'b110010});
    end
    run_cycle(mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 1, 1, 1), 1'b1, got);
    check("freeze_then_flush", {26'd0, got}, {26'd0, 6'b001100});
    busy_n = 0;
    for (int k = 0; k < 10; k++) begin
      run_cycle(idle, 1'b1, got);
      if (got[0]) busy_n++;
    end
    check("mul_busy_cycles", busy_n, MULC - 1);

    // Randomized traffic with a small register space to provoke matches
    for (int n = 0; n < 3000; n++) begin
      rnd.rst = ($urandom_range(0, 99) == 0);
      rnd.rs  = 5'($urandom_range(0, 3));
      rnd.rt  = 5'($urandom_range(0, 3));
      rnd.rd  = 5'($urandom_range(0, 3));
      rnd.urs = 1'($urandom_range(0, 1));
      rnd.urt = 1'($urandom_range(0, 1));
      rnd.mdr = ($urandom_range(0, 99) < 15);
      rnd.mdo = ($urandom_range(0, 99) < 10);
      rnd.mr  = ($urandom_range(0, 99) < 40);
      rnd.ms  = ($urandom_range(0, 99) < 8);
      rnd.dv  = 1'($urandom_range(0, 1));
      rnd.br  = ($urandom_range(0, 99) < 15);
      rnd.im  = ($urandom_range(0, 99) < 85);
      rnd.dm  = ($urandom_range(0, 99) < 85);
      run_cycle(rnd, 1'b1, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
